// File: rtl/async_fifo_pkg.sv
// Shared constants and helpers for the dual-clock FIFO.
// Gray conversion is kept here so both pointer domains agree on it.
package async_fifo_pkg;

  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/fifo_sync_2ff.sv
// Two-flop synchronizer for a Gray-coded pointer bus.
// Only one bit changes per update, so a bus-wide sync is safe.
module fifo_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  // shift the foreign-domain value through the two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // both stages clear to zero on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/async_fifo.sv
// Dual-clock FIFO with Gray pointers crossing via 2-flop syncs.
// Flags are registered from next-state pointers, so they are exact on set.
module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             wclk,
  input  logic             rclk,
  input  logic             rst_n,
  input  logic             wreq,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rreq,
  output logic [DSIZE-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << ASIZE;
  localparam int PW    = ASIZE + 1;

  logic [DSIZE-1:0] mem [DEPTH];

  logic [PW-1:0] wbin_d, wbin_q;
  logic [PW-1:0] wgray_d, wgray_q;
  logic          full_d, full_q;
  logic          winc;
  logic [PW-1:0] wq2_rgray;

  logic [PW-1:0]    rbin_d, rbin_q;
  logic [PW-1:0]    rgray_d, rgray_q;
  logic             empty_d, empty_q;
  logic [DSIZE-1:0] rdata_d, rdata_q;
  logic             rinc;
  logic [PW-1:0]    rq2_wgray;

  // read pointer into the write domain
  fifo_sync_2ff #(.WIDTH(PW)) u_sync_r2w (
    .clk   (wclk),
    .rst_n (rst_n),
    .d     (rgray_q),
    .q     (wq2_rgray)
  );

  // write pointer into the read domain
  fifo_sync_2ff #(.WIDTH(PW)) u_sync_w2r (
    .clk   (rclk),
    .rst_n (rst_n),
    .d     (wgray_q),
    .q     (rq2_wgray)
  );

  // next write pointer and full: one lap ahead of the synced read ptr
  always_comb begin
    winc    = wreq && !full_q;
    wbin_d  = wbin_q + PW'(winc);
    wgray_d = PW'(bin2gray(32'(wbin_d)));
    full_d  = (wgray_d == {~wq2_rgray[PW-1:PW-2],
                           wq2_rgray[PW-3:0]});
  end

  // write-domain state
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
    end
  end

  // storage array, contents need no reset
  always_ff @(posedge wclk) begin
    if (winc) mem[wbin_q[ASIZE-1:0]] <= wdata;
  end

  // next read pointer, empty flag and output word
  always_comb begin
    rinc    = rreq && !empty_q;
    rbin_d  = rbin_q + PW'(rinc);
    rgray_d = PW'(bin2gray(32'(rbin_d)));
    empty_d = (rgray_d == rq2_wgray);
    rdata_d = rinc ? mem[rbin_q[ASIZE-1:0]] : rdata_q;
  end

  // read-domain state
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      rbin_q  <= '0;
      rgray_q <= '0;
      empty_q <= 1'b1;
      rdata_q <= '0;
    end else begin
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      empty_q <= empty_d;
      rdata_q <= rdata_d;
    end
  end

  assign full  = full_q;
  assign empty = empty_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_async_fifo.sv
// Scoreboard bench for async_fifo at default size.
// Accepted writes are queued; accepted reads pop and compare.
module tb_async_fifo;

  logic       wclk  = 1'b0;
  logic       rclk  = 1'b0;
  logic       rst_n = 1'b0;
  logic       wreq  = 1'b0;
  logic       rreq  = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  always #5  wclk = ~wclk;
  always #15 rclk = ~rclk;

  async_fifo #(.DSIZE(8), .ASIZE(4)) dut (
    .wclk  (wclk),
    .rclk  (rclk),
    .rst_n (rst_n),
    .wreq  (wreq),
    .wdata (wdata),
    .rreq  (rreq),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  task automatic wr_cycle(input logic req, input logic [7:0] d,
                          output logic acc);
    wreq  = req;
    wdata = d;
    acc   = req && !full;
    if (acc) sb.push_back(d);
    @(posedge wclk);
    #1;
    wreq = 1'b0;
  endtask

  task automatic rd_cycle(input logic req, output logic acc,
                          output logic [7:0] got);
    rreq = req;
    acc  = req && !empty;
    @(posedge rclk);
    #1;
    rreq = 1'b0;
    got  = rdata;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #20;
    checks++;
    if (full !== 1'b0) begin
      errors++;
      $display("FAIL reset_full got %b exp 0", full);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_empty got %b exp 1", empty);
    end
    checks++;
    if (rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_rdata got %h exp 00", rdata);
    end
    @(negedge wclk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_fill;
    logic acc;
    @(posedge wclk);
    #1;
    for (int i = 1; i <= 16; i++) begin
      wr_cycle(1'b1, 8'(i), acc);
      checks++;
      if (acc !== 1'b1) begin
        errors++;
        $display("FAIL fill_accept word %0d full was %b exp 0", i, full);
      end
      if (i == 15) begin
        checks++;
        if (full !== 1'b0) begin
          errors++;
          $display("FAIL fill_full15 got %b exp 0", full);
        end
      end
    end
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL fill_full16 got %b exp 1", full);
    end
    repeat (4) @(posedge rclk);
    #1;
    checks++;
    if (empty !== 1'b0) begin
      errors++;
      $display("FAIL fill_empty got %b exp 0", empty);
    end
  endtask

  task automatic test_overflow;
    logic acc;
    @(posedge wclk);
    #1;
    for (int i = 0; i < 5; i++) begin
      wr_cycle(1'b1, 8'd16, acc);
      checks++;
      if (acc !== 1'b0) begin
        errors++;
        $display("FAIL ovf_accept try %0d got %b exp 0", i, acc);
      end
    end
    checks++;
    if (sb.size() != 16) begin
      errors++;
      $display("FAIL ovf_depth got %0d exp 16", sb.size());
    end
  endtask

  task automatic test_drain;
    logic       acc;
    logic [7:0] got;
    logic [7:0] exp;
    @(posedge rclk);
    #1;
    for (int i = 1; i <= 16; i++) begin
      rd_cycle(1'b1, acc, got);
      checks++;
      if (acc !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL drain_accept read %0d empty %b exp 0", i, empty);
      end else begin
        exp = sb.pop_front();
        if (got !== exp || got !== 8'(i)) begin
          errors++;
          $display("FAIL drain_data read %0d got %h exp %h", i, got, exp);
        end
      end
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty got %b exp 1", empty);
    end
  endtask

  task automatic test_underflow;
    logic       acc;
    logic [7:0] got;
    for (int i = 0; i < 3; i++) begin
      rd_cycle(1'b1, acc, got);
      checks++;
      if (acc !== 1'b0 || got !== 8'd16) begin
        errors++;
        $display("FAIL udf_hold try %0d got %h exp 10", i, got);
      end
    end
  endtask

  task automatic test_wrap;
    int         nw = 0;
    int         nr = 0;
    logic [7:0] last = 8'd16;
    fork
      begin : writer
        logic acc;
        @(posedge wclk);
        #1;
        for (int g = 0; g < 2000 && nw < 40; g++) begin
          wr_cycle(1'($urandom_range(0, 1)), 8'($urandom), acc);
          if (acc) begin
            nw++;
            checks++;
            if (sb.size() > 16) begin
              errors++;
              $display("FAIL wrap_overflow depth %0d exp <=16", sb.size());
            end
          end
        end
      end
      begin : reader
        logic       acc;
        logic [7:0] got;
        logic [7:0] exp;
        @(posedge rclk);
        #1;
        for (int g = 0; g < 2000 && nr < 40; g++) begin
          rd_cycle(1'($urandom_range(0, 1)), acc, got);
          checks++;
          if (acc) begin
            nr++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL wrap_underflow read %0d got %h exp none",
                       nr, got);
            end else begin
              exp = sb.pop_front();
              if (got !== exp) begin
                errors++;
                $display("FAIL wrap_data read %0d got %h exp %h",
                         nr, got, exp);
              end
              last = exp;
            end
          end else if (got !== last) begin
            errors++;
            $display("FAIL wrap_hold got %h exp %h", got, last);
          end
        end
      end
    join
    checks++;
    if (nw != 40 || nr != 40) begin
      errors++;
      $display("FAIL wrap_timeout writes %0d reads %0d exp 40", nw, nr);
    end
    repeat (4) @(posedge rclk);
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL wrap_flags empty %b full %b exp 1 0", empty, full);
    end
  endtask

  task automatic test_reset_mid;
    logic       acc;
    logic [7:0] got;
    logic [7:0] exp;
    int         g;
    @(posedge wclk);
    #1;
    for (int i = 0; i < 5; i++) wr_cycle(1'b1, 8'(8'h30 + i), acc);
    @(negedge wclk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || rdata !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid empty %b full %b rdata %h exp 1 0 00",
               empty, full, rdata);
    end
    sb.delete();
    #20;
    @(negedge wclk);
    #2;
    rst_n = 1'b1;
    @(posedge wclk);
    #1;
    wr_cycle(1'b1, 8'hA5, acc);
    @(posedge rclk);
    #1;
    g = 0;
    while (empty && g < 10) begin
      @(posedge rclk);
      #1;
      g++;
    end
    checks++;
    if (empty !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_wait empty %b exp 0", empty);
    end else begin
      rd_cycle(1'b1, acc, got);
      exp = (sb.size() != 0) ? sb.pop_front() : 8'h00;
      checks++;
      if (acc !== 1'b1 || got !== exp || got !== 8'hA5) begin
        errors++;
        $display("FAIL rst_mid_data got %h exp a5", got);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/async_fifo.md
ASYNC_FIFO -- requirements
Module: async_fifo

Interface
REQ-001 SHALL have parameter DSIZE, default 8, data word width in bits.
REQ-002 SHALL have parameter ASIZE, default 4, address width; depth = 2**ASIZE (16 at default).
REQ-003 SHALL use one clock per domain, and reset is asynchronous and active-low: every write-side flop on wclk only, every read-side flop on rclk only, no flop on both; rst_n is the shared reset.
REQ-004 wclk  input  1  write-domain clock.
REQ-005 rclk  input  1  read-domain clock, asynchronous to wclk, any frequency ratio.
REQ-006 rst_n  input  1  asynchronous active-low reset for both domains.
REQ-007 wreq  input  1  write request, sampled on posedge wclk.
REQ-008 wdata  input  DSIZE  write data, sampled with wreq.
REQ-009 rreq  input  1  read request, sampled on posedge rclk.
REQ-010 rdata  output  DSIZE  registered read data.
REQ-011 full  output  1  registered in wclk domain; high = no write accepted.
REQ-012 empty  output  1  registered in rclk domain; high = no read accepted.

Function
REQ-013 Write accepted on posedge wclk when wreq && !full: mem[waddr] <= wdata, write pointer +1.
REQ-014 wreq while full SHALL be ignored: no memory or pointer change.
REQ-015 Read accepted on posedge rclk when rreq && !empty: rdata <= mem[raddr], read pointer +1; data is visible right after that same edge (one-edge latency).
REQ-016 rreq while empty SHALL be ignored; rdata holds its previous value.
REQ-017 Pointers: binary and Gray, ASIZE+1 bits each; address = low ASIZE binary bits; the extra MSB distinguishes full from empty on wrap-around.
REQ-018 Gray code = bin ^ (bin >> 1), computed from the next binary pointer and registered.
REQ-019 Read Gray pointer SHALL cross into wclk through a 2-flop synchronizer; write Gray pointer SHALL cross into rclk through a 2-flop synchronizer.
REQ-020 full is registered from the next write Gray pointer: it equals the synchronized read Gray with its two MSBs inverted. full SHALL assert on the same wclk edge that accepts the 2**ASIZE-th outstanding word.
REQ-021 empty is registered as next read Gray == synchronized write Gray. empty SHALL assert on the edge that pops the last word.
REQ-022 Flags are conservative: full deasserts 2-3 wclk edges after a read; empty deasserts 2-3 rclk edges after a write; no overflow or underflow is ever possible.
REQ-023 Memory: 2**ASIZE x DSIZE array, written on wclk, read by address; no reset of contents required.
REQ-024 Simultaneous read and write on the same cycle SHALL each be handled independently in its own domain.

Reset
REQ-025 While rst_n low, asynchronously: all pointers and synchronizer flops = 0, full = 0, empty = 1, rdata = 0.
REQ-026 Reset mid-operation discards all stored words; after release, the FIFO is empty and the next written word is the first one read.

Structure
REQ-027 Package async_fifo_pkg SHALL hold the bin-to-Gray function and default DSIZE/ASIZE constants.
REQ-028 Sub-module fifo_sync_2ff (parameterized width, 2 flops, async active-low reset) SHALL be instantiated twice, once per crossing direction.

Verification
REQ-029 Fill: wclk 10 ns, rclk 30 ns, release reset, write 1..16 on consecutive wclk edges -> full=1 right after the 16th write, empty=0.
REQ-030 Overflow: keep wreq=1 with wdata=16 after full -> no write; a later read-back yields exactly 1..16 in order.
REQ-031 Drain: rreq=1 for 16 rclk edges -> rdata = 1,2,...,16 sampled 1 ns after each posedge rclk; empty=1 after the 16th read.
REQ-032 Underflow: rreq=1 while empty -> rdata stays 16, pointers unchanged.
REQ-033 Wrap-around: interleave 40 writes and reads with random wreq/rreq -> read sequence equals write sequence, and no flag glitches.
REQ-034 Reset mid-stream: 5 words written, assert rst_n -> empty=1, full=0, rdata=0; then write 0xA5 -> first read returns 0xA5.
